// File: rtl/dadda_pkg.sv
// rtl/dadda_pkg.sv - shared widths and product type for the Dadda multiplier family
package dadda_pkg;
  localparam int WIDTH_4 = 4;
  localparam int PROD_W  = 2 * WIDTH_4;

  typedef logic [PROD_W-1:0] prod_t;
endpackage

// File: rtl/dadda_4_if.sv
// rtl/dadda_4_if.sv - operand/product bundle between a multiplier and its user
interface dadda_4_if;
  import dadda_pkg::*;

  logic [WIDTH_4-1:0] in1;
  logic [WIDTH_4-1:0] in2;
  logic [PROD_W-2:0]  out;
  logic               overflow;

  modport master (output in1, output in2, input out, input overflow);
  modport slave  (input in1, input in2, output out, output overflow);
endinterface

// File: rtl/dadda_fa.sv
// rtl/dadda_fa.sv - 1-bit full adder cell; a half adder is this cell with i_cin tied low
module dadda_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/dadda_4.sv
// rtl/dadda_4.sv - registered unsigned 4x4 Dadda multiplier, one clock latency
// Optional build macro DADDA_APPROX_EN: columns 0..2 become OR-approximated, carry-free.
module dadda_4
  import dadda_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  dadda_4_if.slave  bus
);
  if (WIDTH != WIDTH_4) begin : g_bad_width
    $error("dadda_4: WIDTH must be 4");
  end

`ifdef DADDA_APPROX_EN
  localparam int FA_LO = 3;
`else
  localparam int FA_LO = 1;
`endif

  logic [3:0][3:0] w_pp;
  logic            w_s1_3, w_c1_3, w_s1_4, w_c1_4;
  logic            w_s2_3, w_c2_3, w_s2_4, w_c2_4, w_s2_5, w_c2_5;
  logic [6:FA_LO]  w_row_a, w_row_b, w_fs;
  logic [7:FA_LO]  w_fc;
  logic [2:0]      w_low;
  prod_t           w_prod;
  prod_t           r_prod;

  // w_pp[i][j] carries weight i+j
  for (genvar i = 0; i < 4; i++) begin : g_pp_row
    for (genvar j = 0; j < 4; j++) begin : g_pp_col
      assign w_pp[i][j] = bus.in1[j] & bus.in2[i];
    end
  end

  // Stage 1: max height 4 -> 3 (columns 3 and 4)
  dadda_fa u_s1_c3 (.i_a(w_pp[0][3]), .i_b(w_pp[1][2]), .i_cin(1'b0), .o_sum(w_s1_3), .o_cout(w_c1_3));
  dadda_fa u_s1_c4 (.i_a(w_pp[1][3]), .i_b(w_pp[2][2]), .i_cin(1'b0), .o_sum(w_s1_4), .o_cout(w_c1_4));

  // Stage 2: max height 3 -> 2 (columns 2..5; column 2 only in the exact build)
  dadda_fa u_s2_c3 (.i_a(w_s1_3), .i_b(w_pp[2][1]), .i_cin(w_pp[3][0]), .o_sum(w_s2_3), .o_cout(w_c2_3));
  dadda_fa u_s2_c4 (.i_a(w_s1_4), .i_b(w_pp[3][1]), .i_cin(w_c1_3),    .o_sum(w_s2_4), .o_cout(w_c2_4));
  dadda_fa u_s2_c5 (.i_a(w_pp[2][3]), .i_b(w_pp[3][2]), .i_cin(w_c1_4), .o_sum(w_s2_5), .o_cout(w_c2_5));

  assign w_row_a[6:3] = {w_pp[3][3], w_s2_5, w_s2_4, w_s2_3};
  assign w_row_b[6:4] = {w_c2_5, w_c2_4, w_c2_3};

`ifdef DADDA_APPROX_EN
  // Nothing crosses from column 2 into column 3
  assign w_row_b[3] = 1'b0;
  assign w_low[0]   = w_pp[0][0];
  assign w_low[1]   = w_pp[0][1] | w_pp[1][0];
  assign w_low[2]   = w_pp[0][2] | w_pp[1][1] | w_pp[2][0];
`else
  logic w_s2_2, w_c2_2;

  dadda_fa u_s2_c2 (.i_a(w_pp[0][2]), .i_b(w_pp[1][1]), .i_cin(1'b0), .o_sum(w_s2_2), .o_cout(w_c2_2));

  assign w_row_b[3]   = w_c2_2;
  assign w_row_a[2:1] = {w_s2_2, w_pp[0][1]};
  assign w_row_b[2:1] = {w_pp[2][0], w_pp[1][0]};
  assign w_low        = {w_fs[2], w_fs[1], w_pp[0][0]};
`endif

  // Final ripple-carry adder over the two remaining rows
  assign w_fc[FA_LO] = 1'b0;
  for (genvar k = FA_LO; k <= 6; k++) begin : g_cpa
    dadda_fa u_cpa (
      .i_a   (w_row_a[k]),
      .i_b   (w_row_b[k]),
      .i_cin (w_fc[k]),
      .o_sum (w_fs[k]),
      .o_cout(w_fc[k+1])
    );
  end

  assign w_prod = {w_fc[7], w_fs[6:3], w_low};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prod <= '0;
    end else begin
      r_prod <= w_prod;
    end
  end

  assign bus.out      = r_prod[PROD_W-2:0];
  assign bus.overflow = r_prod[PROD_W-1];
endmodule

// File: tb/tb_dadda_4.sv
// tb/tb_dadda_4.sv - directed-vector and exhaustive self-checking bench for dadda_4
module tb_dadda_4;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  dadda_4_if bus ();

  dadda_4 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  // Non-reset results only need to be within the error bound in the approximate build
  task automatic check(input string name, input logic [7:0] exp, input bit is_reset);
    logic [7:0] got;
    bit         ok;
    int         diff;
    got = {bus.overflow, bus.out};
    n_cmp++;
    ok = (got === exp);
`ifdef DADDA_APPROX_EN
    if (!is_reset) begin
      diff = int'(exp) - int'(got);
      ok = !$isunknown(got) && (diff > -16) && (diff < 16);
    end
`else
    diff = 0;
    if (is_reset && diff != 0) ok = 1'b0;
`endif
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (ovf=%0b out=0x%02h) expected %0d", name, got, got[7], got[6:0], exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    vecs[0]  = '{1'b0, 4'hf, 4'hf, 8'd0};
    vecs[1]  = '{1'b1, 4'hf, 4'h1, 8'd15};
    vecs[2]  = '{1'b1, 4'hf, 4'hf, 8'd225};
    vecs[3]  = '{1'b1, 4'h8, 4'h0, 8'd0};
    vecs[4]  = '{1'b1, 4'h8, 4'h8, 8'd64};
    vecs[5]  = '{1'b1, 4'h7, 4'h9, 8'd63};
    vecs[6]  = '{1'b1, 4'ha, 4'hc, 8'd120};
    vecs[7]  = '{1'b1, 4'hb, 4'hc, 8'd132};
    vecs[8]  = '{1'b1, 4'h5, 4'h5, 8'd25};
    vecs[9]  = '{1'b0, 4'hc, 4'hd, 8'd0};
    vecs[10] = '{1'b1, 4'h3, 4'he, 8'd42};
    vecs[11] = '{1'b1, 4'hc, 4'hd, 8'd156};

    rst_n   = 1'b0;
    bus.in1 = 4'h0;
    bus.in2 = 4'h0;
    @(negedge clk);

    // Back-to-back: one operand pair per cycle, each checked one edge later
    for (int v = 0; v < 12; v++) begin
      rst_n   = vecs[v].rst_n;
      bus.in1 = vecs[v].in1;
      bus.in2 = vecs[v].in2;
      @(negedge clk);
      check($sformatf("vec%0d %0dx%0d rst_n=%0b", v, vecs[v].in1, vecs[v].in2, vecs[v].rst_n),
            vecs[v].exp, !vecs[v].rst_n);
    end

    // Outputs hold between edges while inputs change
    rst_n   = 1'b1;
    bus.in1 = 4'hf;
    bus.in2 = 4'hf;
    @(negedge clk);
    check("hold_setup 15x15", 8'd225, 1'b0);
    bus.in1 = 4'h1;
    bus.in2 = 4'h1;
    #3;
    check("hold_between_edges", 8'd225, 1'b0);
    @(negedge clk);
    check("hold_next 1x1", 8'd1, 1'b0);

    // Reset mid-stream with a large product in flight, then recovery
    bus.in1 = 4'he;
    bus.in2 = 4'hf;
    rst_n   = 1'b0;
    @(negedge clk);
    check("midreset", 8'd0, 1'b1);
    rst_n   = 1'b1;
    bus.in1 = 4'h9;
    bus.in2 = 4'hd;
    @(negedge clk);
    check("after_reset 9x13", 8'd117, 1'b0);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus.in1 = 4'(a);
        bus.in2 = 4'(b);
        @(negedge clk);
        check($sformatf("exh %0dx%0d", a, b), 8'(a * b), 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
